// File: rtl/step_seq_pkg.sv
// Shared constants and helpers for the step sequencer: FSM encodings and index clamping.
package step_seq_pkg;

  // FSM state encodings. These are plain 2-bit constants so that older code can
  // compare against them directly.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  // Widest position index supported (N_STEPS up to 256).
  localparam int unsigned IDX_MAX_W = 8;

  // Limit a requested position to the last legal index.
  function automatic logic [IDX_MAX_W-1:0] clamp_idx(input logic [IDX_MAX_W-1:0] val,
                                                     input logic [IDX_MAX_W-1:0] last);
    return (val > last) ? last : val;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Dwell timer: counts enabled cycles and pulses tick on the last cycle of each dwell period.
module dwell_counter #(
  parameter int unsigned DWELL_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // At least one bit, even when the dwell is a single cycle.
  localparam int unsigned CW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // tick is combinational so the owner can step on the same edge that wraps the count.
  assign tick = en && (cnt_q == CNT_LAST);

  // Next count: clear wins, otherwise advance while enabled and wrap on tick.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// N-step position sequencer: steps an index up or down once per dwell period, with pause,
// direction select, synchronous load, and wrap or saturate handling at the ends.
module step_sequencer #(
  parameter  int unsigned N_STEPS   = 4,
  parameter  int unsigned DWELL_CYC = 1,
  parameter  bit          WRAP_EN   = 1'b1,
  localparam int unsigned W         = $clog2(N_STEPS)
) (
  input  logic         iclk,
  input  logic         irst,
  input  logic         iStop,
  input  logic         iback,
  input  logic         iLoad,
  input  logic [W-1:0] iLoadVal,
  output logic [W-1:0] oVal,
  output logic         oTerm,
  output logic         oDone,
  output logic         oRunning
);

  import step_seq_pkg::*;

  // Ends are compared explicitly, since N_STEPS need not be a power of two.
  localparam logic [W-1:0] IDX_LAST = W'(N_STEPS - 1);

  logic [1:0]   state_q, state_d;
  logic [W-1:0] val_q, val_d;
  logic         term_q, term_d;
  logic         done_q, done_d;

  logic         active;
  logic         tick;
  logic         at_end_dir;
  logic         hit_end;
  logic [W-1:0] step_val;
  logic [W-1:0] load_val;

  // A paused sequencer being released counts as a running cycle, so a partial dwell
  // carries on from where it froze instead of losing a cycle.
  assign active = !iLoad && !iStop && ((state_q == ST_RUN) || (state_q == ST_PAUSE));

  dwell_counter #(
    .DWELL_CYC (DWELL_CYC)
  ) u_dwell (
    .clk   (iclk),
    .rst_n (irst),
    .en    (active),
    .clr   (iLoad),
    .tick  (tick)
  );

  // Candidate step value and end detection in the currently selected direction.
  assign at_end_dir = iback ? (val_q == '0) : (val_q == IDX_LAST);
  assign step_val   = iback ? (val_q - W'(1)) : (val_q + W'(1));
  assign hit_end    = iback ? (step_val == '0) : (step_val == IDX_LAST);
  assign load_val   = W'(clamp_idx(IDX_MAX_W'(iLoadVal), IDX_MAX_W'(IDX_LAST)));

  // FSM, position and flag next-state logic; priority is load, then stop, then dwell/step.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    term_d  = 1'b0;
    done_d  = done_q;

    if (iLoad) begin
      val_d   = load_val;
      done_d  = 1'b0;
      state_d = iStop ? ST_PAUSE : ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!iStop) state_d = ST_RUN;
        end
        ST_RUN, ST_PAUSE: begin
          if (iStop) begin
            state_d = ST_PAUSE;
          end else begin
            state_d = ST_RUN;
            if (tick) begin
              if (at_end_dir) begin
                // Already at the end we are heading for: wrap around, or stop there.
                if (WRAP_EN) begin
                  val_d = iback ? IDX_LAST : '0;
                end else begin
                  state_d = ST_HALT;
                  done_d  = 1'b1;
                end
              end else begin
                val_d  = step_val;
                term_d = hit_end;
                if (!WRAP_EN && hit_end) begin
                  state_d = ST_HALT;
                  done_d  = 1'b1;
                end
              end
            end
          end
        end
        ST_HALT: begin
          // Leave saturation once the direction points away from the end we hold.
          if (!at_end_dir) begin
            done_d  = 1'b0;
            state_d = iStop ? ST_PAUSE : ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
          val_d   = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // State, position and flag registers with synchronous active-low reset.
  always_ff @(posedge iclk) begin
    if (!irst) begin
      state_q <= ST_IDLE;
      val_q   <= '0;
      term_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      term_q  <= term_d;
      done_q  <= done_d;
    end
  end

  assign oVal     = val_q;
  assign oTerm    = term_q;
  assign oDone    = done_q;
  assign oRunning = (state_q == ST_RUN);

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: three configurations driven by directed vectors,
// expected outputs queued by the stimulus and compared by an independent monitor.
module tb_step_sequencer;

  // A: N=4 DWELL=1 wrap; B: N=5 DWELL=3 wrap; C: N=6 DWELL=4 saturate.
  logic       clk;
  logic       rst_a, stop_a, back_a, load_a;
  logic [1:0] lval_a, val_a;
  logic       term_a, done_a, run_a;
  logic       rst_b, stop_b, back_b, load_b;
  logic [2:0] lval_b, val_b;
  logic       term_b, done_b, run_b;
  logic       rst_c, stop_c, back_c, load_c;
  logic [2:0] lval_c, val_c;
  logic       term_c, done_c, run_c;

  typedef struct {
    int         id;
    string      name;
    logic [7:0] val;
    logic       term;
    logic       done;
    logic       run;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  byte unsigned t1_v [9]  = '{1, 2, 3, 0, 1, 2, 3, 0, 1};
  bit           t1_t [9]  = '{0, 0, 1, 0, 0, 0, 1, 0, 0};
  byte unsigned t2_v [16] = '{4, 4, 4, 3, 3, 3, 2, 2, 2, 1, 1, 1, 0, 0, 0, 4};
  bit           t2_t [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

  step_sequencer #(.N_STEPS(4), .DWELL_CYC(1), .WRAP_EN(1'b1)) dut_a (
    .iclk(clk), .irst(rst_a), .iStop(stop_a), .iback(back_a), .iLoad(load_a),
    .iLoadVal(lval_a), .oVal(val_a), .oTerm(term_a), .oDone(done_a), .oRunning(run_a)
  );

  step_sequencer #(.N_STEPS(5), .DWELL_CYC(3), .WRAP_EN(1'b1)) dut_b (
    .iclk(clk), .irst(rst_b), .iStop(stop_b), .iback(back_b), .iLoad(load_b),
    .iLoadVal(lval_b), .oVal(val_b), .oTerm(term_b), .oDone(done_b), .oRunning(run_b)
  );

  step_sequencer #(.N_STEPS(6), .DWELL_CYC(4), .WRAP_EN(1'b0)) dut_c (
    .iclk(clk), .irst(rst_c), .iStop(stop_c), .iback(back_c), .iLoad(load_c),
    .iLoadVal(lval_c), .oVal(val_c), .oTerm(term_c), .oDone(done_c), .oRunning(run_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed snapshot {val, term, done, run} of one DUT's outputs.
  function automatic logic [10:0] actual(input int id);
    case (id)
      0:       return {8'(val_a), term_a, done_a, run_a};
      1:       return {8'(val_b), term_b, done_b, run_b};
      default: return {8'(val_c), term_c, done_c, run_c};
    endcase
  endfunction

  task automatic drive(input int id, input logic rst, input logic stop, input logic back,
                       input logic load, input logic [7:0] lval);
    case (id)
      0: begin rst_a = rst; stop_a = stop; back_a = back; load_a = load; lval_a = 2'(lval); end
      1: begin rst_b = rst; stop_b = stop; back_b = back; load_b = load; lval_b = 3'(lval); end
      default: begin
        rst_c = rst; stop_c = stop; back_c = back; load_c = load; lval_c = 3'(lval);
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int id, input string name, input logic [7:0] val,
                            input logic term, input logic done, input logic run);
    exp_t e;
    e.id = id; e.name = name; e.val = val; e.term = term; e.done = done; e.run = run;
    sb.push_back(e);
  endtask

  // Advance n cycles, expecting the same outputs after each edge.
  task automatic hold(input int id, input string name, input int n, input logic [7:0] val,
                      input logic term, input logic done, input logic run);
    for (int i = 0; i < n; i++) begin
      tick();
      expect_out(id, $sformatf("%s_%0d", name, i), val, term, done, run);
    end
  endtask

  // Monitor: compares every queued expectation against the DUT on the falling edge.
  initial begin : monitor
    exp_t        e;
    logic [10:0] got;
    logic [10:0] want;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e    = sb.pop_front();
        got  = actual(e.id);
        want = {e.val, e.term, e.done, e.run};
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL %s: got val=%0d term=%0b done=%0b run=%0b, want val=%0d term=%0b done=%0b run=%0b",
                   e.name, got[10:3], got[2], got[1], got[0], e.val, e.term, e.done, e.run);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // Reset all three instances together.
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(2, 0, 0, 0, 0, 0);
    tick();
    tick();
    expect_out(0, "reset_a", 0, 0, 0, 0);
    expect_out(1, "reset_b", 0, 0, 0, 0);
    expect_out(2, "reset_c", 0, 0, 0, 0);

    // T1: forward every cycle with wrap, then backward wrap, pause and resume.
    drive(0, 1, 0, 0, 0, 0);
    tick(); expect_out(0, "t1_idle_to_run", 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      tick(); expect_out(0, $sformatf("t1_fwd_%0d", i), t1_v[i], t1_t[i], 0, 1);
    end
    drive(0, 1, 0, 1, 0, 0);
    tick(); expect_out(0, "t1_back_term0", 0, 1, 0, 1);
    tick(); expect_out(0, "t1_back_wrap", 3, 0, 0, 1);
    tick(); expect_out(0, "t1_back_2", 2, 0, 0, 1);
    drive(0, 1, 1, 1, 0, 0);
    hold(0, "t1_paused", 2, 2, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 0);
    tick(); expect_out(0, "t1_resume", 1, 0, 0, 1);

    // T2: dwell of 3, backward from reset, wrap 0 -> 4.
    drive(1, 1, 0, 1, 0, 0);
    tick(); expect_out(1, "t2_idle_to_run", 0, 0, 0, 1);
    hold(1, "t2_dwell0", 2, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      tick(); expect_out(1, $sformatf("t2_back_%0d", i), t2_v[i], t2_t[i], 0, 1);
    end

    // T5: load clears dwell; load with stop clamps 7 -> 4, pauses, no terminal pulse.
    drive(1, 1, 0, 0, 1, 1);
    tick(); expect_out(1, "t5_load1", 1, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0);
    tick(); expect_out(1, "t5_dwell1", 1, 0, 0, 1);
    drive(1, 1, 1, 0, 1, 7);
    tick(); expect_out(1, "t5_load_clamp_pause", 4, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    hold(1, "t5_fresh_dwell", 2, 4, 0, 0, 1);
    tick(); expect_out(1, "t5_wrap_fwd", 0, 0, 0, 1);

    // T4: dwell of 4, pause after two dwell cycles, resume continues the partial dwell.
    drive(2, 1, 0, 0, 0, 0);
    tick(); expect_out(2, "t4_idle_to_run", 0, 0, 0, 1);
    hold(2, "t4_dwell", 2, 0, 0, 0, 1);
    drive(2, 1, 1, 0, 0, 0);
    hold(2, "t4_paused", 5, 0, 0, 0, 0);
    drive(2, 1, 0, 0, 0, 0);
    tick(); expect_out(2, "t4_release", 0, 0, 0, 1);
    tick(); expect_out(2, "t4_step", 1, 0, 0, 1);

    // T3: saturate forward at 5, hold in HALT, reverse out, step back after a full dwell.
    drive(2, 1, 0, 0, 1, 4);
    tick(); expect_out(2, "t3_load4", 4, 0, 0, 1);
    drive(2, 1, 0, 0, 0, 0);
    hold(2, "t3_dwell_a", 3, 4, 0, 0, 1);
    tick(); expect_out(2, "t3_sat_fwd", 5, 1, 1, 0);
    hold(2, "t3_halt", 2, 5, 0, 1, 0);
    drive(2, 1, 0, 1, 0, 0);
    tick(); expect_out(2, "t3_reverse", 5, 0, 0, 1);
    hold(2, "t3_dwell_b", 3, 5, 0, 0, 1);
    tick(); expect_out(2, "t3_step_back", 4, 0, 0, 1);

    // Saturate backward at 0.
    drive(2, 1, 0, 1, 1, 1);
    tick(); expect_out(2, "t3_load1", 1, 0, 0, 1);
    drive(2, 1, 0, 1, 0, 0);
    hold(2, "t3_dwell_c", 3, 1, 0, 0, 1);
    tick(); expect_out(2, "t3_sat_back", 0, 1, 1, 0);

    // Load out of HALT clamps to the end; trying to step past it halts with no pulse.
    drive(2, 1, 0, 0, 1, 7);
    tick(); expect_out(2, "t3_load_clamp", 5, 0, 0, 1);
    drive(2, 1, 0, 0, 0, 0);
    hold(2, "t3_dwell_d", 3, 5, 0, 0, 1);
    tick(); expect_out(2, "t3_sat_hold", 5, 0, 1, 0);

    // T6: reset mid-dwell together with a load; reset wins and the dwell restarts.
    drive(2, 1, 0, 0, 1, 2);
    tick(); expect_out(2, "t6_load2", 2, 0, 0, 1);
    drive(2, 1, 0, 0, 0, 0);
    hold(2, "t6_dwell", 2, 2, 0, 0, 1);
    drive(2, 0, 0, 0, 1, 4);
    tick(); expect_out(2, "t6_reset_wins", 0, 0, 0, 0);
    drive(2, 1, 1, 0, 0, 0);
    tick(); expect_out(2, "t6_idle_stopped", 0, 0, 0, 0);
    drive(2, 1, 0, 0, 0, 0);
    tick(); expect_out(2, "t6_idle_to_run", 0, 0, 0, 1);
    hold(2, "t6_dwell_fresh", 3, 0, 0, 0, 1);
    tick(); expect_out(2, "t6_step", 1, 0, 0, 1);

    // Let the monitor drain the last expectation.
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
